uart_prog_loader: RTL and testbench

- UART boot loader on the write side of the core's program/data memory. The core only reads that memory; this block fills it.
- Receives a framed program image on a serial RX line and assembles 32-bit little-endian words.
- Writes the words to consecutive memory addresses starting at 0.
- Holds the core in reset until an image has loaded and its checksum has passed.

---
 rtl/uart_prog_loader_if.sv | 13 +
 rtl/uart_prog_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Memory write bus driven by the UART program loader.
// The loader drives it as master; the program/data memory samples it as slave.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;

  modport master (output mem_addr, output mem_data, output mem_we);
  modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a framed program image, writes little-endian words
// from address 0 upward and releases the core only after a good checksum.
module uart_prog_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         ADDR_W       = 12,
  parameter int         DATA_W       = 32,
  parameter int         TIMEOUT_CLKS = 1000000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  uart_prog_loader_if.master  mem,
  output logic                core_hold,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {F_IDLE, F_LEN_LO, F_LEN_HI, F_DATA, F_WRITE, F_CSUM} f_state_t;

  rx_state_t         rx_state_reg;
  logic              rx_meta_reg, rx_sync_reg;
  logic [CNT_W-1:0]  rx_cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [7:0]        rx_byte_reg;
  logic              byte_valid_reg, frame_err_reg;

  f_state_t          f_state_reg;
  logic [7:0]        len_lo_reg;
  logic [15:0]       len_reg;
  logic [ADDR_W:0]   word_idx_reg;
  logic [1:0]        byte_idx_reg;
  logic [DATA_W-9:0] word_reg;
  logic [7:0]        csum_reg;
  logic [TMO_W-1:0]  tmo_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic              mem_we_reg;

  assign mem.mem_addr = mem_addr_reg;
  assign mem.mem_data = mem_data_reg;
  assign mem.mem_we   = mem_we_reg;

  // Byte receiver: mid-bit sampling of the synchronized line
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      rx_state_reg   <= R_IDLE;
      rx_cnt_reg     <= '0;
      bit_idx_reg    <= '0;
      rx_byte_reg    <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_sync_reg    <= rx_meta_reg;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (rx_state_reg)
        R_IDLE: begin
          rx_cnt_reg <= '0;
          if (!rx_sync_reg) rx_state_reg <= R_START;
        end
        R_START: begin
          if (rx_cnt_reg == CNT_W'(HALF - 1)) begin
            rx_cnt_reg   <= '0;
            bit_idx_reg  <= '0;
            rx_state_reg <= rx_sync_reg ? R_IDLE : R_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_reg  <= '0;
            rx_byte_reg <= {rx_sync_reg, rx_byte_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 1'b1;
            if (bit_idx_reg == 3'd7) rx_state_reg <= R_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (rx_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
            rx_cnt_reg     <= '0;
            byte_valid_reg <= rx_sync_reg;
            frame_err_reg  <= !rx_sync_reg;
            rx_state_reg   <= R_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame parser and memory writer
  always_ff @(posedge clk) begin
    if (rst) begin
      f_state_reg  <= F_IDLE;
      len_lo_reg   <= '0;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      csum_reg     <= '0;
      tmo_reg      <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_we_reg   <= 1'b0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      mem_we_reg <= 1'b0;
      if (f_state_reg == F_IDLE || byte_valid_reg) tmo_reg <= '0;
      else tmo_reg <= tmo_reg + 1'b1;

      if (f_state_reg != F_IDLE && (frame_err_reg ||
          (!byte_valid_reg && tmo_reg == TMO_W'(TIMEOUT_CLKS - 1)))) begin
        err         <= 1'b1;
        busy        <= 1'b0;
        f_state_reg <= F_IDLE;
      end else begin
        case (f_state_reg)
          F_IDLE: begin
            if (byte_valid_reg && rx_byte_reg == SYNC_BYTE) begin
              busy         <= 1'b1;
              core_hold    <= 1'b1;
              done         <= 1'b0;
              err          <= 1'b0;
              word_idx_reg <= '0;
              byte_idx_reg <= '0;
              csum_reg     <= '0;
              f_state_reg  <= F_LEN_LO;
            end
          end
          F_LEN_LO: begin
            if (byte_valid_reg) begin
              len_lo_reg  <= rx_byte_reg;
              f_state_reg <= F_LEN_HI;
            end
          end
          F_LEN_HI: begin
            if (byte_valid_reg) begin
              len_reg <= {rx_byte_reg, len_lo_reg};
              if ({rx_byte_reg, len_lo_reg} == 16'd0) begin
                f_state_reg <= F_CSUM;
              end else if (32'({rx_byte_reg, len_lo_reg}) > (32'd1 << ADDR_W)) begin
                err         <= 1'b1;
                busy        <= 1'b0;
                f_state_reg <= F_IDLE;
              end else begin
                f_state_reg <= F_DATA;
              end
            end
          end
          F_DATA: begin
            if (byte_valid_reg) begin
              csum_reg     <= csum_reg ^ rx_byte_reg;
              byte_idx_reg <= byte_idx_reg + 1'b1;
              case (byte_idx_reg)
                2'd0: word_reg[7:0]   <= rx_byte_reg;
                2'd1: word_reg[15:8]  <= rx_byte_reg;
                2'd2: word_reg[23:16] <= rx_byte_reg;
                default: begin
                  // Last lane goes straight to the bus so mem_we follows the byte by one cycle
                  mem_we_reg   <= 1'b1;
                  mem_addr_reg <= word_idx_reg[ADDR_W-1:0];
                  mem_data_reg <= {rx_byte_reg, word_reg};
                  f_state_reg  <= F_WRITE;
                end
              endcase
            end
          end
          F_WRITE: begin
            word_idx_reg <= word_idx_reg + 1'b1;
            if (32'(word_idx_reg) + 32'd1 == 32'(len_reg)) f_state_reg <= F_CSUM;
            else f_state_reg <= F_DATA;
          end
          default: begin
            if (byte_valid_reg) begin
              if (rx_byte_reg == csum_reg) begin
                done      <= 1'b1;
                core_hold <= 1'b0;
              end else begin
                err <= 1'b1;
              end
              busy        <= 1'b0;
              f_state_reg <= F_IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: table of whole frames plus hand-written
// sequences for framing error, timeout, reset mid-frame and in-field reload.
module tb_uart_prog_loader;
  localparam int CPB    = 4;
  localparam int TMO    = 200;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic core_hold, busy, done, err;

  uart_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT_CLKS(TMO), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem(mem_bus),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [DATA_W-1:0] wr_data_q[$];

  // Every cycle with mem_we high is logged as one write
  always @(negedge clk) begin
    if (mem_bus.mem_we) begin
      wr_addr_q.push_back(mem_bus.mem_addr);
      wr_data_q.push_back(mem_bus.mem_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string          name;
    logic [14*8-1:0] bytes;  // first byte sent is the most significant of the n used
    int             n;
    int             nw;
    logic [31:0]    d0;
    logic [31:0]    d1;
    logic           exp_done;
    logic           exp_err;
    logic           exp_hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic chk_writes(input string name, input int nw, input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] exp_d;
    chk({name, ".wcount"}, 32'(wr_addr_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      exp_d = (k == 0) ? d0 : d1;
      chk($sformatf("%s.addr%0d", name, k), 32'(wr_addr_q[k]), 32'(k));
      chk($sformatf("%s.data%0d", name, k), wr_data_q[k], exp_d);
    end
  endtask

  task automatic run_vec(input vec_t v);
    clear_writes();
    for (int i = 0; i < v.n; i++) send_byte(v.bytes[(v.n - 1 - i) * 8 +: 8], 1'b1);
    tick(10);
    @(negedge clk);
    chk_writes(v.name, v.nw, v.d0, v.d1);
    chk({v.name, ".done"}, 32'(done), 32'(v.exp_done));
    chk({v.name, ".err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, ".core_hold"}, 32'(core_hold), 32'(v.exp_hold));
    chk({v.name, ".busy"}, 32'(busy), 32'd0);
    $display("[TB] frame %-10s writes=%0d done=%0b err=%0b core_hold=%0b",
             v.name, wr_addr_q.size(), done, err, core_hold);
  endtask

  task automatic chk_reset_vals(input string name);
    @(negedge clk);
    chk({name, ".mem_addr"}, 32'(mem_bus.mem_addr), 32'd0);
    chk({name, ".mem_data"}, mem_bus.mem_data, 32'd0);
    chk({name, ".mem_we"}, 32'(mem_bus.mem_we), 32'd0);
    chk({name, ".core_hold"}, 32'(core_hold), 32'd1);
    chk({name, ".busy"}, 32'(busy), 32'd0);
    chk({name, ".done"}, 32'(done), 32'd0);
    chk({name, ".err"}, 32'(err), 32'd0);
    $display("[TB] %s: addr=%0h data=%08h we=%0b hold=%0b busy=%0b done=%0b err=%0b",
             name, mem_bus.mem_addr, mem_bus.mem_data, mem_bus.mem_we, core_hold, busy, done, err);
  endtask

  initial begin
    // XOR of 78 56 34 12 EF BE AD DE is 0x2A, so 0x00 and 0x88 are both bad checksums
    vecs[0] = '{"load", {8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h2A},
                12, 2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"badcsum", {8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h00},
                12, 2, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{"badcsum88", {8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h88},
                12, 2, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{"garbage", {8'h00,8'hFF,8'h5A,8'hA5,8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h44},
                11, 1, 32'h44332211, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"len0", {8'hA5,8'h00,8'h00,8'h00},
                4, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"midsync", {8'hA5,8'h01,8'h00,8'hA5,8'h00,8'h00,8'h00,8'hA5},
                8, 1, 32'h000000A5, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"toolong", {8'hA5,8'h01,8'h10},
                3, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    tick(4);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(10);

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // In-field reload: SYNC after done must re-assert core_hold and clear done
    run_vec(vecs[4]);
    clear_writes();
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    chk("reload.core_hold", 32'(core_hold), 32'd1);
    chk("reload.busy", 32'(busy), 32'd1);
    chk("reload.done", 32'(done), 32'd0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    tick(5);
    @(negedge clk);
    chk("reload.done_after", 32'(done), 32'd1);
    chk("reload.hold_after", 32'(core_hold), 32'd0);
    $display("[TB] reload: done=%0b core_hold=%0b", done, core_hold);

    // Framing error on the 2nd data byte
    clear_writes();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    tick(20);
    @(negedge clk);
    chk("framing.err", 32'(err), 32'd1);
    chk("framing.busy", 32'(busy), 32'd0);
    chk("framing.done", 32'(done), 32'd0);
    chk("framing.wcount", 32'(wr_addr_q.size()), 32'd0);
    $display("[TB] framing: err=%0b busy=%0b writes=%0d", err, busy, wr_addr_q.size());

    // Timeout: still busy well inside the limit, aborted once past it
    clear_writes();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    tick(100);
    @(negedge clk);
    chk("timeout.busy_before", 32'(busy), 32'd1);
    chk("timeout.err_before", 32'(err), 32'd0);
    tick(150);
    @(negedge clk);
    chk("timeout.err", 32'(err), 32'd1);
    chk("timeout.busy", 32'(busy), 32'd0);
    chk("timeout.wcount", 32'(wr_addr_q.size()), 32'd0);
    $display("[TB] timeout: err=%0b busy=%0b writes=%0d", err, busy, wr_addr_q.size());

    // Reset after two data bytes, then a full valid frame
    clear_writes();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_reset_vals("midrst");
    tick(10);
    chk("midrst.wcount", 32'(wr_addr_q.size()), 32'd0);
    run_vec(vecs[0]);
    chk("midrst.last_addr", 32'(mem_bus.mem_addr), 32'd1);
    chk("midrst.last_data", mem_bus.mem_data, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
